// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction-memory and decode-stage handshake bundle for ifu_fetch
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_id;
  logic [31:0] pc_id;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_id, pc_id,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_id, pc_id,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch unit with redirect squash
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          jump_flag,
  input  logic [31:0]   jump_target,
  ifu_fetch_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] jump_pc;

  assign jump_pc = jump_target & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_id_q <= 32'h0;
      pc_id_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_id_q <= inst_id_d;
      pc_id_q   <= pc_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_id_d = inst_id_q;
    pc_id_d   = pc_id_q;
    if (jump_flag) begin
      pc_d = jump_pc;
    end
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.imem_req_ready) begin
          state_d = ST_WAIT;
          drop_d  = jump_flag;
        end
      end
      ST_WAIT: begin
        // A redirect seen before or with the response makes that response stale.
        if (bus.imem_rsp_valid) begin
          if (drop_q || jump_flag) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_id_d = bus.imem_rsp_data;
            pc_id_d   = pc_q;
            state_d   = ST_HOLD;
          end
        end else if (jump_flag) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (jump_flag) begin
          state_d = ST_REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.imem_req_valid = (state_q == ST_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == ST_HOLD);
  assign bus.inst_id        = inst_id_q;
  assign bus.pc_id          = pc_id_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed scoreboard bench for ifu_fetch
module tb_ifu_fetch;
  logic        clk;
  logic        rst_n;
  logic        rst_b_n;
  logic        jump_flag;
  logic [31:0] jump_target;
  logic        jump_b;
  logic [31:0] jump_target_b;

  int n_cmp;
  int n_fail;
  logic [63:0] sb_q[$];

  ifu_fetch_if bus_a();
  ifu_fetch_if bus_b();

  ifu_fetch u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_flag   (jump_flag),
    .jump_target (jump_target),
    .bus         (bus_a)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk         (clk),
    .rst_n       (rst_b_n),
    .jump_flag   (jump_b),
    .jump_target (jump_target_b),
    .bus         (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string tag, input logic v, input logic [31:0] id, input logic [31:0] pc);
    logic [63:0] e;
    chk({tag, "_valid"}, {31'b0, v}, 32'd1);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pc"}, pc, e[63:32]);
      chk({tag, "_inst"}, id, e[31:0]);
    end
  endtask

  task automatic chk_req(input string tag, input logic [31:0] addr);
    chk({tag, "_rv"}, {31'b0, bus_a.imem_req_valid}, 32'd1);
    chk({tag, "_addr"}, bus_a.imem_req_addr, addr);
    chk({tag, "_iv"}, {31'b0, bus_a.inst_valid}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    rst_b_n = 1'b0;
    jump_flag = 1'b0;
    jump_target = 32'h0;
    jump_b = 1'b0;
    jump_target_b = 32'h0;
    bus_a.imem_req_ready = 1'b0;
    bus_a.imem_rsp_valid = 1'b0;
    bus_a.imem_rsp_data = 32'h0;
    bus_a.inst_ready = 1'b0;
    bus_b.imem_req_ready = 1'b0;
    bus_b.imem_rsp_valid = 1'b0;
    bus_b.imem_rsp_data = 32'h0;
    bus_b.inst_ready = 1'b0;

    tick();
    chk("rst_req_valid", {31'b0, bus_a.imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, bus_a.inst_valid}, 32'd0);
    chk("rst_inst_id", bus_a.inst_id, 32'h0);
    chk("rst_pc_id", bus_a.pc_id, 32'h0);
    tick();
    rst_n = 1'b1;

    // basic fetch, zero-wait memory
    tick();
    chk_req("f0", 32'h8000_0000);
    bus_a.imem_req_ready = 1'b1;
    tick();
    bus_a.imem_req_ready = 1'b0;
    chk("f0_wait_rv", {31'b0, bus_a.imem_req_valid}, 32'd0);
    chk("f0_wait_iv", {31'b0, bus_a.inst_valid}, 32'd0);
    bus_a.imem_rsp_valid = 1'b1;
    bus_a.imem_rsp_data = 32'h0000_0413;
    sb_q.push_back({32'h8000_0000, 32'h0000_0413});
    tick();
    bus_a.imem_rsp_valid = 1'b0;
    chk_inst("f0", bus_a.inst_valid, bus_a.inst_id, bus_a.pc_id);

    // decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_iv", {31'b0, bus_a.inst_valid}, 32'd1);
      chk("hold_id", bus_a.inst_id, 32'h0000_0413);
      chk("hold_pc", bus_a.pc_id, 32'h8000_0000);
      chk("hold_rv", {31'b0, bus_a.imem_req_valid}, 32'd0);
    end
    bus_a.inst_ready = 1'b1;
    tick();
    bus_a.inst_ready = 1'b0;
    chk_req("f1", 32'h8000_0004);

    // memory not ready: address stable, then redirect without handshake
    tick();
    chk_req("stall", 32'h8000_0004);
    jump_flag = 1'b1;
    jump_target = 32'h8000_0041;
    tick();
    jump_flag = 1'b0;
    chk_req("jreq", 32'h8000_0040);

    // redirect while waiting, then the stale response
    bus_a.imem_req_ready = 1'b1;
    tick();
    bus_a.imem_req_ready = 1'b0;
    jump_flag = 1'b1;
    jump_target = 32'h8000_0103;
    tick();
    jump_flag = 1'b0;
    chk("jwait_rv", {31'b0, bus_a.imem_req_valid}, 32'd0);
    chk("jwait_iv", {31'b0, bus_a.inst_valid}, 32'd0);
    bus_a.imem_rsp_valid = 1'b1;
    bus_a.imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    bus_a.imem_rsp_valid = 1'b0;
    chk_req("jwait_next", 32'h8000_0100);
    chk("jwait_id_kept", bus_a.inst_id, 32'h0000_0413);

    bus_a.imem_req_ready = 1'b1;
    tick();
    bus_a.imem_req_ready = 1'b0;
    bus_a.imem_rsp_valid = 1'b1;
    bus_a.imem_rsp_data = 32'h1111_1111;
    sb_q.push_back({32'h8000_0100, 32'h1111_1111});
    tick();
    bus_a.imem_rsp_valid = 1'b0;
    chk_inst("f2", bus_a.inst_valid, bus_a.inst_id, bus_a.pc_id);

    // redirect in HOLD together with consume
    jump_flag = 1'b1;
    jump_target = 32'h8000_0200;
    bus_a.inst_ready = 1'b1;
    tick();
    jump_flag = 1'b0;
    bus_a.inst_ready = 1'b0;
    chk_req("jhold", 32'h8000_0200);

    // redirect coinciding with the request handshake
    jump_flag = 1'b1;
    jump_target = 32'h8000_0300;
    bus_a.imem_req_ready = 1'b1;
    tick();
    jump_flag = 1'b0;
    bus_a.imem_req_ready = 1'b0;
    bus_a.imem_rsp_valid = 1'b1;
    bus_a.imem_rsp_data = 32'hDEAD_BEE1;
    tick();
    bus_a.imem_rsp_valid = 1'b0;
    chk_req("jhs", 32'h8000_0300);

    // redirect and response in the same WAIT cycle
    bus_a.imem_req_ready = 1'b1;
    tick();
    bus_a.imem_req_ready = 1'b0;
    bus_a.imem_rsp_valid = 1'b1;
    bus_a.imem_rsp_data = 32'hDEAD_BEE2;
    jump_flag = 1'b1;
    jump_target = 32'h8000_0402;
    tick();
    bus_a.imem_rsp_valid = 1'b0;
    jump_flag = 1'b0;
    chk_req("jrsp", 32'h8000_0400);

    bus_a.imem_req_ready = 1'b1;
    tick();
    bus_a.imem_req_ready = 1'b0;
    bus_a.imem_rsp_valid = 1'b1;
    bus_a.imem_rsp_data = 32'h2222_2222;
    sb_q.push_back({32'h8000_0400, 32'h2222_2222});
    tick();
    bus_a.imem_rsp_valid = 1'b0;
    chk_inst("f3", bus_a.inst_valid, bus_a.inst_id, bus_a.pc_id);
    bus_a.inst_ready = 1'b1;
    tick();
    bus_a.inst_ready = 1'b0;
    chk_req("f4", 32'h8000_0404);

    // reset while waiting, stale response after release
    bus_a.imem_req_ready = 1'b1;
    tick();
    bus_a.imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_rv", {31'b0, bus_a.imem_req_valid}, 32'd0);
    chk("mrst_iv", {31'b0, bus_a.inst_valid}, 32'd0);
    chk("mrst_id", bus_a.inst_id, 32'h0);
    chk("mrst_pc", bus_a.pc_id, 32'h0);
    tick();
    rst_n = 1'b1;
    bus_a.imem_rsp_valid = 1'b1;
    bus_a.imem_rsp_data = 32'h5555_AAAA;
    tick();
    chk_req("mrst_restart", 32'h8000_0000);
    tick();
    bus_a.imem_rsp_valid = 1'b0;
    chk_req("mrst_ignored", 32'h8000_0000);
    chk("mrst_id_clear", bus_a.inst_id, 32'h0);

    // pc wrap on the second instance
    rst_b_n = 1'b1;
    tick();
    chk("wrap0_rv", {31'b0, bus_b.imem_req_valid}, 32'd1);
    chk("wrap0_addr", bus_b.imem_req_addr, 32'hFFFF_FFFC);
    bus_b.imem_req_ready = 1'b1;
    tick();
    bus_b.imem_req_ready = 1'b0;
    bus_b.imem_rsp_valid = 1'b1;
    bus_b.imem_rsp_data = 32'h0000_0013;
    sb_q.push_back({32'hFFFF_FFFC, 32'h0000_0013});
    tick();
    bus_b.imem_rsp_valid = 1'b0;
    chk_inst("wrap", bus_b.inst_valid, bus_b.inst_id, bus_b.pc_id);
    bus_b.inst_ready = 1'b1;
    tick();
    bus_b.inst_ready = 1'b0;
    chk("wrap1_rv", {31'b0, bus_b.imem_req_valid}, 32'd1);
    chk("wrap1_addr", bus_b.imem_req_addr, 32'h0000_0000);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
